mat_addsub: RTL

MAT_ADDSUB -- requirements
Module: mat_addsub

---
 rtl/mat_pkg.sv | 20 ++
 rtl/mat_addsub_adder.sv | 84 ++++++++
 rtl/mat_addsub.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mat_pkg.sv
// Shared definitions for the matrix add/subtract block: element width,
// controller state encoding and flat element addressing.
package mat_pkg;

    localparam int FP_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        STORE,
        DONE
    } state_e;

    // Element (r,c) lives at flat index k = r*COLS + c; this returns its bit offset.
    function automatic int elem_offset(input int k);
        return k * FP_W;
    endfunction

endpackage

// File: rtl/mat_addsub_adder.sv
// Single-precision float adder (round-to-nearest-even, denormals flushed to zero).
// Result and result_ready register on the edge that samples load; result_ready holds until result_ack.
module adder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] Number1,
    input  logic [31:0] Number2,
    output logic        result_ready,
    input  logic        result_ack,
    output logic [31:0] Result
);
    logic        swap, sL, sS, sticky;
    logic [7:0]  eL, eS, d;
    logic [22:0] fL, fS, frac;
    logic [26:0] xL, xS, shS, mask, norm;
    logic [27:0] acc;
    logic [4:0]  lz;
    logic [9:0]  expN, expR;
    logic [24:0] rnd;
    logic [31:0] sum;
    logic        ready_q;
    logic [31:0] result_q;

    // Align the smaller magnitude onto the larger with guard/round/sticky bits,
    // add or subtract, renormalise, then round to nearest even.
    always_comb begin
        swap         = Number2[30:0] > Number1[30:0];
        {sL, eL, fL} = swap ? Number2 : Number1;
        {sS, eS, fS} = swap ? Number1 : Number2;
        d      = eL - eS;
        xL     = (eL == 8'd0) ? 27'd0 : {1'b1, fL, 3'b000};
        xS     = (eS == 8'd0) ? 27'd0 : {1'b1, fS, 3'b000};
        shS    = xS >> d;
        mask   = (27'd1 << d) - 27'd1;
        sticky = |(xS & mask);
        if (sL == sS)
            acc = {1'b0, xL} + {1'b0, shS | {26'd0, sticky}};
        else
            acc = {1'b0, xL} - {1'b0, shS | {26'd0, sticky}};

        lz = 5'd0;
        for (int i = 0; i < 27; i++)
            if (acc[i]) lz = 5'(26 - i);
        if (acc[27]) begin
            norm = {acc[27:2], acc[1] | acc[0]};
            expN = {2'b00, eL} + 10'd1;
        end else begin
            norm = acc[26:0] << lz;
            expN = {2'b00, eL} - {5'd0, lz};
        end

        rnd  = {1'b0, norm[26:3]} + {24'd0, norm[2] & (norm[3] | norm[1] | norm[0])};
        expR = rnd[24] ? expN + 10'd1 : expN;
        frac = rnd[24] ? rnd[23:1] : rnd[22:0];

        if (eL == 8'hFF)
            sum = ((fL != 23'd0) || (eS == 8'hFF && sL != sS)) ? 32'h7FC00000 : {sL, 8'hFF, 23'd0};
        else if (acc == 28'd0)
            sum = {sL & sS, 31'd0};
        else if (expR[9] || expR == 10'd0)
            sum = {sL, 31'd0};
        else if (expR >= 10'd255)
            sum = {sL, 8'hFF, 23'd0};
        else
            sum = {sL, expR[7:0], frac};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q  <= 1'b0;
            result_q <= 32'd0;
        end else if (load) begin
            ready_q  <= 1'b1;
            result_q <= sum;
        end else if (result_ack) begin
            ready_q  <= 1'b0;
        end
    end

    assign result_ready = ready_q;
    assign Result       = result_q;

endmodule

// File: rtl/mat_addsub.sv
// Element-wise single-precision matrix add/subtract, walking the elements in
// row-major order through one shared float adder.
module mat_addsub
    import mat_pkg::*;
#(
    parameter int ROWS = 2,
    parameter int COLS = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      a_stb,
    input  logic                      b_stb,
    input  logic                      mode,
    input  logic [ROWS*COLS*FP_W-1:0] A,
    input  logic [ROWS*COLS*FP_W-1:0] B,
    output logic                      a_ack,
    output logic                      b_ack,
    output logic                      busy,
    output logic                      result_ready,
    input  logic                      result_ack,
    output logic [ROWS*COLS*FP_W-1:0] result
);
    localparam int            N      = ROWS * COLS;
    localparam int            KW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    state_e            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [N*FP_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic              mode_q, mode_d;
    logic              ack_q, ack_d;
    logic              add_load, add_ready, add_ack;
    logic [FP_W-1:0]   add_num1, add_num2, add_result;

    // Subtraction is done by flipping the sign of the B element on its way to the adder.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        mode_d   = mode_q;
        ack_d    = 1'b0;
        add_load = 1'b0;
        add_ack  = 1'b0;
        add_num1 = a_q[elem_offset(int'(k_q)) +: FP_W];
        add_num2 = b_q[elem_offset(int'(k_q)) +: FP_W] ^ {mode_q, {(FP_W-1){1'b0}}};

        case (state_q)
            IDLE: begin
                if (a_stb && b_stb) begin
                    a_d     = A;
                    b_d     = B;
                    mode_d  = mode;
                    k_d     = '0;
                    ack_d   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                add_load = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                if (add_ready) state_d = STORE;
            end
            STORE: begin
                res_d[elem_offset(int'(k_q)) +: FP_W] = add_result;
                add_ack = 1'b1;
                if (k_q == K_LAST) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + KW'(1);
                    state_d = ISSUE;
                end
            end
            DONE: begin
                if (result_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            mode_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            mode_q  <= mode_d;
            ack_q   <= ack_d;
        end
    end

    adder u_adder (
        .clk          (clk),
        .rst_n        (~reset),
        .load         (add_load),
        .Number1      (add_num1),
        .Number2      (add_num2),
        .result_ready (add_ready),
        .result_ack   (add_ack),
        .Result       (add_result)
    );

    assign a_ack        = ack_q;
    assign b_ack        = ack_q;
    assign busy         = (state_q != IDLE);
    assign result_ready = (state_q == DONE);
    assign result       = res_q;

endmodule
